// File: rtl/demux_pkg.sv
// Shared sizing and types for the 10-way, 16-bit demultiplexer.
// The select index type is shared with the mux10 side of the path.
package demux_pkg;

  localparam int DEMUX_WIDTH = 16;
  localparam int DEMUX_LANES = 10;
  localparam int DEMUX_SELW  = 4;
  localparam int DEMUX_CNTW  = 8;

  typedef logic [DEMUX_SELW-1:0] lane_idx_t;

endpackage

// File: rtl/demux_lane.sv
// Single-entry register slice for one demux output lane.
// A refill wins over a drain in the same cycle, which avoids a bubble and keeps full throughput.
module demux_lane #(
  parameter int WIDTH = demux_pkg::DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // The data register is not cleared on a drain, so the last word stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (wr_en) begin
      r_valid <= 1'b1;
      r_data  <= wr_data;
    end else if (r_valid && rd_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;

endmodule

// File: rtl/demux10_reg.sv
// Registered 1-to-LANES demultiplexer with per-lane valid/ready handshakes.
// Out-of-range selects are accepted without stalling, then dropped, flagged and counted.
module demux10_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int LANES = DEMUX_LANES,
  parameter int SELW  = DEMUX_SELW,
  parameter int CNTW  = DEMUX_CNTW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]    in_sel,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]   out_valid,
  input  logic [LANES-1:0]   out_ready,
  output logic               err_sel,
  output logic [CNTW-1:0]    drop_count
);

  localparam logic [SELW:0]   LANES_W = (SELW+1)'(LANES);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  lane_idx_t        w_sel;
  logic             w_inRange;
  logic             w_accept;
  logic [LANES-1:0] w_selOneHot;
  logic [LANES-1:0] w_laneOpen;
  logic [LANES-1:0] w_wrEn;
  logic             w_dropAccept;

  logic             r_errSel;
  logic [CNTW-1:0]  r_dropCount;

  assign w_sel     = lane_idx_t'(in_sel);
  assign w_inRange = ({1'b0, in_sel} < LANES_W);

  // A lane is open when empty or draining this cycle; this is the out_ready -> in_ready path.
  always_comb begin
    w_selOneHot = '0;
    w_laneOpen  = '0;
    for (int i = 0; i < LANES; i++) begin
      w_selOneHot[i] = (w_sel == lane_idx_t'(i));
      w_laneOpen[i]  = !out_valid[i] || out_ready[i];
    end
  end

  assign in_ready     = w_inRange ? |(w_selOneHot & w_laneOpen) : 1'b1;
  assign w_accept     = in_valid && in_ready;
  assign w_wrEn       = (w_accept && w_inRange) ? w_selOneHot : '0;
  assign w_dropAccept = w_accept && !w_inRange;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    demux_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_wrEn[g]),
      .wr_data (in_data),
      .rd_ready(out_ready[g]),
      .valid   (out_valid[g]),
      .data    (out_data[g*WIDTH +: WIDTH])
    );
  end

  // The drop counter saturates rather than wrapping so a flood of bad selects stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_errSel    <= 1'b0;
      r_dropCount <= '0;
    end else begin
      r_errSel <= w_dropAccept;
      if (w_dropAccept && (r_dropCount != CNT_MAX)) begin
        r_dropCount <= r_dropCount + 1'b1;
      end
    end
  end

  assign err_sel    = r_errSel;
  assign drop_count = r_dropCount;

endmodule

// File: tb/tb_demux10_reg.sv
// Directed self-checking bench for demux10_reg with hand-computed expectations.
module tb_demux10_reg;

  localparam int WIDTH = 16;
  localparam int LANES = 10;
  localparam int SELW  = 4;
  localparam int CNTW  = 8;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SELW-1:0]        in_sel;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_valid;
  logic [LANES-1:0]       out_ready;
  logic                   err_sel;
  logic [CNTW-1:0]        drop_count;

  int checkCount = 0;
  int errorCount = 0;

  logic [15:0] laneWords [10] = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E,
                                  16'h000F, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
  logic [3:0]  badSels [3] = '{4'hA, 4'hF, 4'hC};

  demux10_reg dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_sel   (err_sel),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] laneData(input int idx);
    return out_data[idx*WIDTH +: WIDTH];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] sel, input logic [15:0] data);
    in_valid = valid;
    in_sel   = sel;
    in_data  = data;
    #1;
  endtask

  initial begin
    int modelCount;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '1;
    stepCycle();
    stepCycle();
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_drop_count", 32'(drop_count), 32'h0);
    checkOutput("reset_err_sel", 32'(err_sel), 32'h0);
    checkOutput("reset_out_data", 32'(|out_data), 32'h0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'h1);

    // Test 1: one word per lane, all consumers ready.
    for (int i = 0; i < LANES; i++) begin
      applyStimulus(1'b1, 4'(i), laneWords[i]);
      checkOutput($sformatf("t1_in_ready_%0d", i), 32'(in_ready), 32'h1);
      stepCycle();
      checkOutput($sformatf("t1_valid_%0d", i), 32'(out_valid[i]), 32'h1);
      checkOutput($sformatf("t1_data_%0d", i), 32'(laneData(i)), 32'(laneWords[i]));
    end
    applyStimulus(1'b0, 4'h0, 16'h0);
    stepCycle();
    checkOutput("t1_all_drained", 32'(out_valid), 32'h0);

    // Test 2: backpressure on lane 3.
    out_ready[3] = 1'b0;
    applyStimulus(1'b1, 4'd3, 16'h000D);
    stepCycle();
    applyStimulus(1'b1, 4'd3, 16'h1234);
    checkOutput("t2_in_ready_stall", 32'(in_ready), 32'h0);
    stepCycle();
    checkOutput("t2_valid_held", 32'(out_valid[3]), 32'h1);
    checkOutput("t2_data_held", 32'(laneData(3)), 32'h000D);
    out_ready[3] = 1'b1;
    #1;
    checkOutput("t2_in_ready_open", 32'(in_ready), 32'h1);
    stepCycle();
    checkOutput("t2_valid_refill", 32'(out_valid[3]), 32'h1);
    checkOutput("t2_data_refill", 32'(laneData(3)), 32'h1234);
    applyStimulus(1'b0, 4'd3, 16'h0);
    stepCycle();
    checkOutput("t2_valid_drained", 32'(out_valid[3]), 32'h0);
    checkOutput("t2_data_kept", 32'(laneData(3)), 32'h1234);

    // Test 3: drain and refill of lane 5 in the same cycle.
    out_ready[5] = 1'b0;
    applyStimulus(1'b1, 4'd5, 16'h000F);
    stepCycle();
    checkOutput("t3_valid_first", 32'(out_valid[5]), 32'h1);
    out_ready[5] = 1'b1;
    applyStimulus(1'b1, 4'd5, 16'hABCD);
    checkOutput("t3_in_ready", 32'(in_ready), 32'h1);
    stepCycle();
    checkOutput("t3_valid_no_bubble", 32'(out_valid[5]), 32'h1);
    checkOutput("t3_data_refill", 32'(laneData(5)), 32'hABCD);
    applyStimulus(1'b0, 4'd0, 16'h0);
    stepCycle();
    checkOutput("t3_all_drained", 32'(out_valid), 32'h0);

    // Test 4: three bad selects back to back.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, badSels[i], 16'hDEAD);
      checkOutput($sformatf("t4_in_ready_%0d", i), 32'(in_ready), 32'h1);
      stepCycle();
      checkOutput($sformatf("t4_err_sel_%0d", i), 32'(err_sel), 32'h1);
      checkOutput($sformatf("t4_out_valid_%0d", i), 32'(out_valid), 32'h0);
      checkOutput($sformatf("t4_drop_%0d", i), 32'(drop_count), 32'(i + 1));
    end
    applyStimulus(1'b0, 4'hF, 16'h0);
    stepCycle();
    checkOutput("t4_err_sel_clear", 32'(err_sel), 32'h0);
    checkOutput("t4_drop_idle", 32'(drop_count), 32'h3);

    // Test 5: saturate the drop counter, then reset.
    modelCount = 3;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 4'hA + 4'(i % 6), 16'h0);
      stepCycle();
      if (modelCount < 255) modelCount++;
    end
    checkOutput("t5_drop_sat", 32'(drop_count), 32'(modelCount));
    checkOutput("t5_drop_ff", 32'(drop_count), 32'hFF);
    checkOutput("t5_err_sel", 32'(err_sel), 32'h1);
    applyStimulus(1'b0, 4'h0, 16'h0);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("t5_rst_drop", 32'(drop_count), 32'h0);
    checkOutput("t5_rst_err", 32'(err_sel), 32'h0);
    checkOutput("t5_rst_valid", 32'(out_valid), 32'h0);

    // Test 6: reset beats a concurrent write and drain.
    out_ready[7] = 1'b0;
    applyStimulus(1'b1, 4'd7, 16'h7777);
    stepCycle();
    checkOutput("t6_lane7_loaded", 32'(out_valid[7]), 32'h1);
    out_ready[7] = 1'b1;
    rst = 1'b1;
    applyStimulus(1'b1, 4'd2, 16'h2222);
    stepCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 4'd0, 16'h0);
    checkOutput("t6_lane2_valid", 32'(out_valid[2]), 32'h0);
    checkOutput("t6_all_valid", 32'(out_valid), 32'h0);
    checkOutput("t6_all_data", 32'(|out_data), 32'h0);
    checkOutput("t6_drop", 32'(drop_count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/demux10_reg.md
Name: demux10_reg

Overview:
- Registered 1-to-10 demultiplexer. It is the distribution end of the 10-way, 16-bit select path that mux10 gathers.
- It accepts one 16-bit word per cycle, tagged with a 4-bit destination select, and steers the word into one of ten single-entry output lanes.
- Each lane has its own valid/ready handshake, so the downstream consumers drain independently.
- Out-of-range selects are dropped and counted.

Parameters:
- WIDTH, 16, data word width.
- LANES, 10, number of output lanes. Must satisfy LANES <= 2**SELW.
- SELW, 4, select width.
- CNTW, 8, width of the drop counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept this cycle; combinational.
- in_data  in  WIDTH  input word.
- in_sel  in  SELW  destination lane index.
- out_data  out  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  LANES  lane i holds a word.
- out_ready  in  LANES  consumer i takes the word this cycle.
- err_sel  out  1  one-cycle pulse after an out-of-range select is accepted.
- drop_count  out  CNTW  saturating count of dropped words.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, err_sel=0, drop_count=0.
  - A transfer or drain presented in the same cycle is discarded.
  - in_ready is still driven combinationally during reset. Its value is ignored because nothing commits.
- Accept (handshake):
  - Transfer occurs when in_valid && in_ready at a clk edge.
  - When in_sel < LANES: in_ready = !out_valid[in_sel] || out_ready[in_sel]. A full lane accepts only when it drains in the same cycle.
  - When in_sel >= LANES: in_ready = 1, so a bad select never stalls the input.
- Lane write:
  - Applies to an accepted word with in_sel=k < LANES.
  - On the next edge: data of lane k <= in_data and out_valid[k] <= 1.
  - Latency is one cycle, input edge to out_valid.
- Lane drain:
  - out_valid[i] && out_ready[i] clears out_valid[i] on the edge.
  - out_data[i] holds its last value after drain; it is not cleared.
- Simultaneous drain and refill of the same lane: refill wins. out_valid stays 1 and data takes the new word, with no bubble. This gives full throughput of one word per cycle per lane.
- Independent lanes: a write to lane k and drains on any other lanes proceed in the same cycle.
- out_ready[i] while out_valid[i]=0: ignored, no state change.
- Bad select (accepted word with in_sel >= LANES, i.e. 10..15):
  - No lane changes.
  - err_sel=1 for exactly the following cycle.
  - drop_count increments by 1 and saturates at 2**CNTW-1 (255); it never wraps.
- Back-to-back bad selects: err_sel stays high on each following cycle, and the count increments each time.
- in_valid=0: in_sel and in_data are don't-care. No counting, no error.
- Stalled input (in_valid=1, in_ready=0): nothing commits. The source must hold in_data/in_sel stable until accepted.
- Combinational path: out_ready to in_ready through the lane select. This path is documented and allowed.
- No state machine beyond the per-lane valid flag. err_sel and drop_count are registered.

Decomposition:
- Shared package demux_pkg holds:
  - DEMUX_WIDTH=16, DEMUX_LANES=10, DEMUX_SELW=4, DEMUX_CNTW=8.
  - A lane_idx_t typedef of SELW bits.
- One sub-module, demux_lane: single-entry register slice with wr_en, wr_data, rd_ready, valid and data outputs, plus refill-wins logic.
  - Instantiated LANES times by generate.
  - Top level holds select decode, in_ready mux and the error/drop counter.

Test Plan:
1. Reset, then send d0..d9 = 000A,000B,000C,000D,000E,000F,0001,0002,0003,0004 with in_sel = 0..9, one per cycle, all out_ready=1.
   - Expect lane i out_valid high one cycle after its write, with out_data[i] = d_i.
   - in_ready stays 1 throughout.
2. out_ready[3]=0; write 000D to lane 3, then 1234 to lane 3.
   - Expect in_ready=0 on the second word, and lane 3 still holds 000D.
   - Raise out_ready[3]: the second word is accepted that cycle, and out_data[3]=1234 next cycle with out_valid[3] held high throughout.
3. Lane 5 full with 000F and out_ready[5]=1; write ABCD to lane 5 in the same cycle.
   - Expect out_valid[5] to stay 1 and out_data[5]=ABCD next cycle, with no bubble.
4. Send in_sel = 4'hA, 4'hF, 4'hC on consecutive cycles.
   - Expect err_sel high for three cycles and drop_count=3.
   - No out_valid changes; in_ready stays 1.
5. Drive 300 consecutive bad selects.
   - Expect drop_count to saturate at 8'hFF.
   - Then assert rst for one cycle: drop_count=0, err_sel=0, all out_valid=0 on the next edge.
6. Assert rst in the same cycle as a valid write to lane 2 and a drain on lane 7.
   - Expect lane 2 out_valid=0 after the edge and all out_data=0.
